board_line_scanner: RTL and testbench
=====================================

Name: board_line_scanner

Overview:
- Transmit side of the four-in-a-row piece stream.
- Snapshots the packed game board on `start`.
- Emits every win-capable line (rows, columns, both diagonals of length >= WIN_LEN) as a stream of 2-bit pieces, one per clock, with a 2'b00 separator after each line.
- Output feeds the sequence recognizer's `in` input, which replaces the preloaded 398-bit combo vector.

Parameters:
- ROWS, 6, board height; row 0 is the bottom row.
- COLS, 7, board width.
- WIN_LEN, 4, minimum diagonal length emitted.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- board  input  2*ROWS*COLS  cell (r,c) at bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)]; 00 empty, 01 red, 10 yellow, 11 illegal.
- start  input  1  begin a scan; sampled only in IDLE.
- piece_out  output  2  current piece, or 00 on separator cycles.
- piece_valid  output  1  piece_out is meaningful this cycle.
- line_end  output  1  high on separator cycles only.
- busy  output  1  high from the cycle after start is accepted through the last separator.
- done  output  1  one-cycle pulse after the final separator.

Behaviour:
- Reset (async, any time, including mid-scan): all outputs go to 0 and the FSM goes to IDLE. No partial line is completed after reset releases.
- FSM states: IDLE -> ROWS -> COLS -> DIAG_UP -> DIAG_DN -> FIN -> IDLE.
- IDLE: start=1 at edge k latches board into an internal snapshot. Changes to board after edge k have no effect. First piece_valid appears in cycle k+1. All outputs are registered.
- Each scanning state emits its lines in the order below. Each cell takes one cycle (piece_valid=1, line_end=0). Each line is followed by one separator cycle (piece_out=00, piece_valid=1, line_end=1).
- ROWS: r = 0..ROWS-1; within a row c = 0..COLS-1.
- COLS: c = 0..COLS-1; within a column r = 0..ROWS-1.
- DIAG_UP (r+1, c+1 per step):
  - Start cells in order: (ROWS-WIN_LEN,0) down to (1,0), then (0,0), then (0,1) up to (0,COLS-WIN_LEN).
  - Walk each diagonal until it leaves the board.
- DIAG_DN (r-1, c+1 per step):
  - Start cells in order: (WIN_LEN-1,0) up to (ROWS-1,0), then (ROWS-1,1) up to (ROWS-1,COLS-WIN_LEN).
  - Walk each diagonal until it leaves the board.
- Transitions between states add no idle cycles. The separator of a state's last line is followed immediately by the next state's first cell.
- FIN: one cycle with done=1, busy=0, piece_valid=0, then IDLE.
- Illegal cell value 11 is emitted as 00.
- start while busy or in FIN is ignored; it is not queued.
- start in the IDLE cycle immediately after FIN is accepted normally.
- Default 6x7 board:
  - 144 cells + 25 separators = 169 stream cycles.
  - Diagonal lengths per direction are 4,5,6,6,5,4.
  - Stream index ranges: rows 0..47, columns 48..96, DIAG_UP 97..132, DIAG_DN 133..168.
- Counters:
  - Row and column counters are $clog2(max(ROWS,COLS)) bits wide.
  - Bounds checks use compare-before-increment, with no wrap-around.
- piece_valid is 0 whenever busy is 0.

Test Plan:
- Empty board, start pulse at edge 0 -> piece_valid high in cycles 1..169 with piece_out=00 throughout; 25 line_end pulses; done=1 in cycle 170 only; busy low in cycle 170.
- Bottom row all 01, rest empty -> stream indices 0..6 = 01, index 7 = 00 with line_end=1; every column's first cell (indices 48,55,...,90) = 01.
- Single 01 at (0,0) -> 01 appears exactly at stream indices 0, 48 and 108, and nowhere else.
- Cell (2,3)=11, all other cells 10 -> every cell cycle emits 10 except the cycles for (2,3), which emit 00.
- Hold start high for 200 cycles from IDLE -> first scan completes with done at cycle 170; a second scan begins after FIN, with its first piece in cycle 172.
- Assert reset at stream index 60 -> piece_valid, line_end, busy and done drop immediately (asynchronously); a new start after release rescans from index 0 using the newly latched board.

Source files
------------

// File: rtl/board_line_scanner.sv
// Streams every win-capable line of a snapshotted game board as 2-bit pieces,
// one per clock, with a 00/line_end separator after each line.
module board_line_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2*ROWS*COLS-1:0] board,
  input  logic                   start,
  output logic [1:0]             piece_out,
  output logic                   piece_valid,
  output logic                   line_end,
  output logic                   busy,
  output logic                   done
);

  localparam int NCELL = ROWS * COLS;
  localparam int BITS  = 2 * NCELL;
  localparam int MAXD  = (ROWS > COLS) ? ROWS : COLS;
  localparam int CW    = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int BW    = $clog2(BITS);

  localparam logic [CW-1:0] ZERO        = '0;
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] R_LAST      = CW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST      = CW'(COLS - 1);
  localparam logic [CW-1:0] UP_R0       = CW'(ROWS - WIN_LEN);
  localparam logic [CW-1:0] DN_R0       = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] DIAG_C_LAST = CW'(COLS - WIN_LEN);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROWS = 3'd1;
  localparam logic [2:0] ST_COLS = 3'd2;
  localparam logic [2:0] ST_DUP  = 3'd3;
  localparam logic [2:0] ST_DDN  = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  // state/position registers describe the cycle currently on the outputs
  logic [2:0]      state_reg, state_next;
  logic [CW-1:0]   r_reg, r_next;
  logic [CW-1:0]   c_reg, c_next;
  logic            sep_reg, sep_next;
  logic [CW-1:0]   ds_r_reg, ds_r_next;
  logic [CW-1:0]   ds_c_reg, ds_c_next;
  logic            accept;
  logic            scan_next;

  logic [BITS-1:0] clean_board;
  logic [BITS-1:0] snap_reg;
  logic [BITS-1:0] src_board;
  logic [BW-1:0]   bit_idx;
  logic [1:0]      piece_sel;

  logic [1:0]      piece_out_reg;
  logic            piece_valid_reg;
  logic            line_end_reg;
  logic            busy_reg;
  logic            done_reg;

  // illegal 11 cells are folded to empty before they ever reach the snapshot
  genvar gi;
  generate
    for (gi = 0; gi < NCELL; gi++) begin : g_clean
      assign clean_board[2*gi +: 2] =
        (board[2*gi +: 2] == 2'b11) ? 2'b00 : board[2*gi +: 2];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    sep_next   = sep_reg;
    ds_r_next  = ds_r_reg;
    ds_c_next  = ds_c_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_ROWS;
          r_next     = ZERO;
          c_next     = ZERO;
          sep_next   = 1'b0;
        end
      end
      ST_ROWS: begin
        if (sep_reg) begin
          sep_next = 1'b0;
          c_next   = ZERO;
          if (r_reg == R_LAST) begin
            state_next = ST_COLS;
            r_next     = ZERO;
          end else begin
            r_next = r_reg + ONE;
          end
        end else if (c_reg == C_LAST) begin
          sep_next = 1'b1;
        end else begin
          c_next = c_reg + ONE;
        end
      end
      ST_COLS: begin
        if (sep_reg) begin
          sep_next = 1'b0;
          r_next   = ZERO;
          if (c_reg == C_LAST) begin
            state_next = ST_DUP;
            r_next     = UP_R0;
            c_next     = ZERO;
            ds_r_next  = UP_R0;
            ds_c_next  = ZERO;
          end else begin
            c_next = c_reg + ONE;
          end
        end else if (r_reg == R_LAST) begin
          sep_next = 1'b1;
        end else begin
          r_next = r_reg + ONE;
        end
      end
      ST_DUP: begin
        if (sep_reg) begin
          sep_next = 1'b0;
          // start cells move down column 0, then right along row 0
          if (ds_c_reg == ZERO && ds_r_reg != ZERO) begin
            ds_r_next = ds_r_reg - ONE;
            r_next    = ds_r_reg - ONE;
            c_next    = ZERO;
          end else if (ds_c_reg != DIAG_C_LAST) begin
            ds_r_next = ZERO;
            ds_c_next = ds_c_reg + ONE;
            r_next    = ZERO;
            c_next    = ds_c_reg + ONE;
          end else begin
            state_next = ST_DDN;
            ds_r_next  = DN_R0;
            ds_c_next  = ZERO;
            r_next     = DN_R0;
            c_next     = ZERO;
          end
        end else if (r_reg == R_LAST || c_reg == C_LAST) begin
          sep_next = 1'b1;
        end else begin
          r_next = r_reg + ONE;
          c_next = c_reg + ONE;
        end
      end
      ST_DDN: begin
        if (sep_reg) begin
          sep_next = 1'b0;
          // start cells move up column 0, then right along the top row
          if (ds_c_reg == ZERO && ds_r_reg != R_LAST) begin
            ds_r_next = ds_r_reg + ONE;
            r_next    = ds_r_reg + ONE;
            c_next    = ZERO;
          end else if (ds_c_reg != DIAG_C_LAST) begin
            ds_r_next = R_LAST;
            ds_c_next = ds_c_reg + ONE;
            r_next    = R_LAST;
            c_next    = ds_c_reg + ONE;
          end else begin
            state_next = ST_FIN;
          end
        end else if (r_reg == ZERO || c_reg == C_LAST) begin
          sep_next = 1'b1;
        end else begin
          r_next = r_reg - ONE;
          c_next = c_reg + ONE;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign scan_next = (state_next == ST_ROWS) || (state_next == ST_COLS) ||
                     (state_next == ST_DUP)  || (state_next == ST_DDN);

  // on the accepting edge the snapshot is not loaded yet, so read the live board
  assign src_board = accept ? clean_board : snap_reg;
  assign bit_idx   = BW'(2 * (int'(r_next) * COLS + int'(c_next)));
  assign piece_sel = src_board[bit_idx +: 2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      r_reg           <= ZERO;
      c_reg           <= ZERO;
      sep_reg         <= 1'b0;
      ds_r_reg        <= ZERO;
      ds_c_reg        <= ZERO;
      snap_reg        <= '0;
      piece_out_reg   <= 2'b00;
      piece_valid_reg <= 1'b0;
      line_end_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      r_reg           <= r_next;
      c_reg           <= c_next;
      sep_reg         <= sep_next;
      ds_r_reg        <= ds_r_next;
      ds_c_reg        <= ds_c_next;
      if (accept) begin
        snap_reg <= clean_board;
      end
      piece_out_reg   <= (scan_next && !sep_next) ? piece_sel : 2'b00;
      piece_valid_reg <= scan_next;
      line_end_reg    <= scan_next && sep_next;
      busy_reg        <= scan_next;
      done_reg        <= (state_next == ST_FIN);
    end
  end

  assign piece_out   = piece_out_reg;
  assign piece_valid = piece_valid_reg;
  assign line_end    = line_end_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_board_line_scanner.sv
// Randomized bench for board_line_scanner; expected streams come from a
// loop-based enumeration of rows, columns and diagonals.
module tb_board_line_scanner;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;
  localparam int BITS    = 2 * ROWS * COLS;
  localparam int MAXN    = 512;

  logic            clock;
  logic            reset;
  logic [BITS-1:0] board;
  logic            start;
  logic [1:0]      piece_out;
  logic            piece_valid;
  logic            line_end;
  logic            busy;
  logic            done;

  board_line_scanner #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .board       (board),
    .start       (start),
    .piece_out   (piece_out),
    .piece_valid (piece_valid),
    .line_end    (line_end),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt;
  int chk_cnt;

  logic [1:0] exp_p  [0:MAXN-1];
  logic       exp_le [0:MAXN-1];
  int         exp_n;

  logic [1:0] obs_p  [0:MAXN-1];
  logic       obs_le [0:MAXN-1];
  int         obs_n;
  int         busy_bad;
  logic       timed_out;
  logic       fin_done, fin_busy, fin_valid, post_done;

  function automatic logic [1:0] cell_of(input logic [BITS-1:0] b, input int r, input int c);
    logic [1:0] v;
    v = 2'(b >> (2 * (r * COLS + c)));
    return (v == 2'b11) ? 2'b00 : v;
  endfunction

  function automatic logic [BITS-1:0] rand_board();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[BITS-1:0];
  endfunction

  task automatic push_exp(input logic [1:0] p, input logic le);
    if (exp_n < MAXN) begin
      exp_p[exp_n]  = p;
      exp_le[exp_n] = le;
    end
    exp_n++;
  endtask

  task automatic walk(input logic [BITS-1:0] b, input int r0, input int c0, input int dr);
    int r;
    int c;
    r = r0;
    c = c0;
    while (r >= 0 && r < ROWS && c < COLS) begin
      push_exp(cell_of(b, r, c), 1'b0);
      r += dr;
      c++;
    end
    push_exp(2'b00, 1'b1);
  endtask

  task automatic build_model(input logic [BITS-1:0] b);
    exp_n = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) push_exp(cell_of(b, r, c), 1'b0);
      push_exp(2'b00, 1'b1);
    end
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) push_exp(cell_of(b, r, c), 1'b0);
      push_exp(2'b00, 1'b1);
    end
    for (int sr = ROWS - WIN_LEN; sr >= 0; sr--) walk(b, sr, 0, 1);
    for (int sc = 1; sc <= COLS - WIN_LEN; sc++) walk(b, 0, sc, 1);
    for (int sr = WIN_LEN - 1; sr < ROWS; sr++) walk(b, sr, 0, -1);
    for (int sc = 1; sc <= COLS - WIN_LEN; sc++) walk(b, ROWS - 1, sc, -1);
  endtask

  // Start one scan and record the stream; board is scrambled right after
  // the accepting edge so a missing snapshot shows up as wrong pieces.
  task automatic do_scan(input logic [BITS-1:0] b);
    int guard;
    @(negedge clock);
    board = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    board = rand_board();
    obs_n = 0;
    busy_bad = 0;
    timed_out = 1'b0;
    guard = 0;
    while (piece_valid === 1'b1) begin
      if (obs_n < MAXN) begin
        obs_p[obs_n]  = piece_out;
        obs_le[obs_n] = line_end;
      end
      if (busy !== 1'b1) busy_bad++;
      obs_n++;
      @(negedge clock);
      guard++;
      if (guard > 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    fin_done  = done;
    fin_busy  = busy;
    fin_valid = piece_valid;
    @(negedge clock);
    post_done = done;
  endtask

  task automatic test_reset();
    @(negedge clock);
    chk_cnt++;
    if ({piece_out, piece_valid, line_end, busy, done} !== 6'b0) begin
      $display("FAIL reset_outputs: got %b want 000000", {piece_out, piece_valid, line_end, busy, done});
    end else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
    chk_cnt++;
    if ({piece_valid, busy, done} !== 3'b0) begin
      $display("FAIL idle_after_reset: got %b want 000", {piece_valid, busy, done});
    end else pass_cnt++;
  endtask

  task automatic test_empty();
    int le_cnt;
    do_scan('0);
    build_model('0);
    chk_cnt++;
    if (timed_out !== 1'b0) $display("FAIL empty_timeout: scan exceeded cycle budget");
    else pass_cnt++;
    chk_cnt++;
    if (obs_n != 169) $display("FAIL empty_length: got %0d want 169", obs_n);
    else pass_cnt++;
    le_cnt = 0;
    for (int i = 0; i < obs_n && i < MAXN && i < exp_n; i++) begin
      if (obs_le[i] === 1'b1) le_cnt++;
      chk_cnt++;
      if ({obs_p[i], obs_le[i]} !== {exp_p[i], exp_le[i]})
        $display("FAIL empty_stream[%0d]: got %b/%b want %b/%b", i, obs_p[i], obs_le[i], exp_p[i], exp_le[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (le_cnt != 25) $display("FAIL empty_line_end_count: got %0d want 25", le_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (busy_bad != 0) $display("FAIL empty_busy_during_stream: %0d cycles busy low, want 0", busy_bad);
    else pass_cnt++;
    chk_cnt++;
    if ({fin_done, fin_busy, fin_valid} !== 3'b100)
      $display("FAIL empty_fin_cycle: done/busy/valid got %b want 100", {fin_done, fin_busy, fin_valid});
    else pass_cnt++;
    chk_cnt++;
    if (post_done !== 1'b0) $display("FAIL empty_done_pulse: done after FIN got %b want 0", post_done);
    else pass_cnt++;
  endtask

  task automatic test_bottom_row();
    logic [BITS-1:0] b;
    b = '0;
    for (int c = 0; c < COLS; c++) b[2*c] = 1'b1;
    do_scan(b);
    chk_cnt++;
    if (obs_n != 169) $display("FAIL bottom_length: got %0d want 169", obs_n);
    else pass_cnt++;
    for (int i = 0; i < COLS; i++) begin
      chk_cnt++;
      if ({obs_p[i], obs_le[i]} !== 3'b010)
        $display("FAIL bottom_row[%0d]: got %b/%b want 01/0", i, obs_p[i], obs_le[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({obs_p[7], obs_le[7]} !== 3'b001)
      $display("FAIL bottom_sep7: got %b/%b want 00/1", obs_p[7], obs_le[7]);
    else pass_cnt++;
    for (int j = 0; j < COLS; j++) begin
      chk_cnt++;
      if (obs_p[48 + 7*j] !== 2'b01)
        $display("FAIL bottom_col_first[%0d]: got %b want 01", 48 + 7*j, obs_p[48 + 7*j]);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int hits[$];
    do_scan({{(BITS-2){1'b0}}, 2'b01});
    for (int i = 0; i < obs_n && i < MAXN; i++)
      if (obs_p[i] === 2'b01) hits.push_back(i);
    chk_cnt++;
    if (hits.size() != 3) $display("FAIL single_hit_count: got %0d want 3", hits.size());
    else pass_cnt++;
    if (hits.size() == 3) begin
      chk_cnt++;
      if (hits[0] != 0 || hits[1] != 48 || hits[2] != 108)
        $display("FAIL single_hit_pos: got %0d,%0d,%0d want 0,48,108", hits[0], hits[1], hits[2]);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal();
    logic [BITS-1:0] b;
    int n10, n00, bad;
    for (int i = 0; i < ROWS*COLS; i++) b[2*i +: 2] = 2'b10;
    b[2*(2*COLS+3) +: 2] = 2'b11;
    do_scan(b);
    build_model(b);
    n10 = 0; n00 = 0; bad = 0;
    for (int i = 0; i < obs_n && i < MAXN && i < exp_n; i++) begin
      if (obs_le[i] !== 1'b1) begin
        if (obs_p[i] === 2'b10) n10++;
        else if (obs_p[i] === 2'b00) n00++;
      end
      if ({obs_p[i], obs_le[i]} !== {exp_p[i], exp_le[i]}) bad++;
    end
    chk_cnt++;
    if (n10 != 140) $display("FAIL illegal_count10: got %0d want 140", n10);
    else pass_cnt++;
    chk_cnt++;
    if (n00 != 4) $display("FAIL illegal_count00: got %0d want 4", n00);
    else pass_cnt++;
    chk_cnt++;
    if (bad != 0 || obs_n != exp_n)
      $display("FAIL illegal_stream: %0d mismatching cycles, length %0d want %0d", bad, obs_n, exp_n);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [BITS-1:0] b;
    for (int t = 0; t < 4; t++) begin
      b = rand_board();
      do_scan(b);
      build_model(b);
      chk_cnt++;
      if (obs_n != exp_n) $display("FAIL random%0d_length: got %0d want %0d", t, obs_n, exp_n);
      else pass_cnt++;
      for (int i = 0; i < obs_n && i < MAXN && i < exp_n; i++) begin
        chk_cnt++;
        if ({obs_p[i], obs_le[i]} !== {exp_p[i], exp_le[i]})
          $display("FAIL random%0d_stream[%0d]: got %b/%b want %b/%b", t, i, obs_p[i], obs_le[i], exp_p[i], exp_le[i]);
        else pass_cnt++;
      end
      chk_cnt++;
      if ({fin_done, fin_busy, fin_valid} !== 3'b100)
        $display("FAIL random%0d_fin: done/busy/valid got %b want 100", t, {fin_done, fin_busy, fin_valid});
      else pass_cnt++;
    end
  endtask

  task automatic test_start_held();
    int first_done, second_valid, guard;
    @(negedge clock);
    board = rand_board();
    start = 1'b1;
    first_done = 0;
    second_valid = 0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clock);
      if (done === 1'b1 && first_done == 0) first_done = t;
      if (piece_valid === 1'b1 && first_done != 0 && second_valid == 0) second_valid = t;
    end
    start = 1'b0;
    chk_cnt++;
    if (first_done != 170) $display("FAIL held_first_done: got cycle %0d want 170", first_done);
    else pass_cnt++;
    chk_cnt++;
    if (second_valid != 172) $display("FAIL held_second_start: got cycle %0d want 172", second_valid);
    else pass_cnt++;
    guard = 0;
    while (done !== 1'b1 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    chk_cnt++;
    if (done !== 1'b1) $display("FAIL held_second_done: done got %b want 1 within budget", done);
    else pass_cnt++;
    repeat (3) @(negedge clock);
    chk_cnt++;
    if ({busy, piece_valid} !== 2'b00) $display("FAIL held_no_queue: busy/valid got %b want 00", {busy, piece_valid});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [BITS-1:0] a, b;
    int stray;
    a = rand_board();
    build_model(a);
    @(negedge clock);
    board = a;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (60) @(negedge clock);
    chk_cnt++;
    if ({piece_valid, piece_out} !== {1'b1, exp_p[60]})
      $display("FAIL mid_index60: valid/piece got %b/%b want 1/%b", piece_valid, piece_out, exp_p[60]);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({piece_out, piece_valid, line_end, busy, done} !== 6'b0)
      $display("FAIL mid_async_reset: got %b want 000000", {piece_out, piece_valid, line_end, busy, done});
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clock);
      if ({piece_valid, busy, done, line_end} !== 4'b0) stray++;
    end
    chk_cnt++;
    if (stray != 0) $display("FAIL mid_no_resume: %0d active cycles after release, want 0", stray);
    else pass_cnt++;
    b = rand_board();
    do_scan(b);
    build_model(b);
    chk_cnt++;
    if (obs_n != exp_n) $display("FAIL mid_rescan_length: got %0d want %0d", obs_n, exp_n);
    else pass_cnt++;
    for (int i = 0; i < obs_n && i < MAXN && i < exp_n; i++) begin
      chk_cnt++;
      if ({obs_p[i], obs_le[i]} !== {exp_p[i], exp_le[i]})
        $display("FAIL mid_rescan[%0d]: got %b/%b want %b/%b", i, obs_p[i], obs_le[i], exp_p[i], exp_le[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    reset = 1'b1;
    start = 1'b0;
    board = '0;
    test_reset();
    test_empty();
    test_bottom_row();
    test_single();
    test_illegal();
    test_random();
    test_start_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
